// File: rtl/half_adder_intf_if.sv
`default_nettype none
// ============================================================================
// half_adder_intf_if : operand/result bundle for half_adder_intf
// Revision 1.0 -- initial release (HALF_ADDER_INTF_STATS_EN adds counter signals)
// ============================================================================
interface half_adder_intf_if #(
   parameter int WIDTH = 1
`ifdef HALF_ADDER_INTF_STATS_EN
 , parameter int CNT_W = 16
`endif
);
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] sum_comb;
   logic [WIDTH-1:0] carry_comb;
   logic             out_valid;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] carry;
`ifdef HALF_ADDER_INTF_STATS_EN
   logic             stats_clr;
   logic [CNT_W-1:0] op_count;
   logic [CNT_W-1:0] carry_count;

   modport master (
      output in_valid, a, b, stats_clr,
      input  sum_comb, carry_comb, out_valid, sum, carry, op_count, carry_count
   );
   modport slave (
      input  in_valid, a, b, stats_clr,
      output sum_comb, carry_comb, out_valid, sum, carry, op_count, carry_count
   );
`else
   modport master (
      output in_valid, a, b,
      input  sum_comb, carry_comb, out_valid, sum, carry
   );
   modport slave (
      input  in_valid, a, b,
      output sum_comb, carry_comb, out_valid, sum, carry
   );
`endif
endinterface
`default_nettype wire

// File: rtl/half_adder_intf.sv
`default_nettype none
// ============================================================================
// half_adder_intf : per-lane half adder, combinational and registered results
// Macro HALF_ADDER_INTF_STATS_EN adds saturating op/carry counters.
// Revision 1.0 -- initial release
// ============================================================================
module half_adder_intf #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   half_adder_intf_if.slave bus
);
   if (WIDTH < 1 || WIDTH > 32 || CNT_W < 4 || CNT_W > 32) begin : g_param_check
      $error("half_adder_intf: WIDTH or CNT_W out of range");
   end

   logic [WIDTH-1:0] sum_d,   sum_q;
   logic [WIDTH-1:0] carry_d, carry_q;
   logic             out_valid_d, out_valid_q;
   logic             armed_q;
   logic             accept;

   assign bus.sum_comb   = bus.a ^ bus.b;
   assign bus.carry_comb = bus.a & bus.b;

   // The first edge after reset release only arms the block, so an
   // in_valid coinciding with that edge is dropped.
   assign accept = bus.in_valid & armed_q;

   always_comb begin
      sum_d       = sum_q;
      carry_d     = carry_q;
      out_valid_d = accept;
      if (accept) begin
         sum_d   = bus.a ^ bus.b;
         carry_d = bus.a & bus.b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed_q     <= 1'b0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         carry_q     <= '0;
      end else begin
         armed_q     <= 1'b1;
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         carry_q     <= carry_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.carry     = carry_q;

`ifdef HALF_ADDER_INTF_STATS_EN
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] op_count_d,    op_count_q;
   logic [CNT_W-1:0] carry_count_d, carry_count_q;

   always_comb begin
      op_count_d    = op_count_q;
      carry_count_d = carry_count_q;
      if (bus.stats_clr) begin
         op_count_d    = '0;
         carry_count_d = '0;
      end else if (accept) begin
         // Saturate at all-ones instead of wrapping.
         if (!(&op_count_q)) begin
            op_count_d = op_count_q + CNT_ONE;
         end
         if ((|(bus.a & bus.b)) && !(&carry_count_q)) begin
            carry_count_d = carry_count_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count_q    <= '0;
         carry_count_q <= '0;
      end else begin
         op_count_q    <= op_count_d;
         carry_count_q <= carry_count_d;
      end
   end

   assign bus.op_count    = op_count_q;
   assign bus.carry_count = carry_count_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_half_adder_intf.sv
`default_nettype none
// ============================================================================
// tb_half_adder_intf : scoreboard bench for half_adder_intf (WIDTH=1 and WIDTH=4)
// Revision 1.0 -- initial release (stats scenarios need HALF_ADDER_INTF_STATS_EN)
// ============================================================================
module tb_half_adder_intf;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   errors  = 0;

   logic [1:0] q1 [$];
   logic [7:0] q4 [$];

   always #5 clk = ~clk;

`ifdef HALF_ADDER_INTF_STATS_EN
   half_adder_intf_if #(.WIDTH(1), .CNT_W(4))  bus1 ();
   half_adder_intf_if #(.WIDTH(4), .CNT_W(16)) bus4 ();
`else
   half_adder_intf_if #(.WIDTH(1)) bus1 ();
   half_adder_intf_if #(.WIDTH(4)) bus4 ();
`endif

   half_adder_intf #(.WIDTH(1), .CNT_W(4))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   half_adder_intf #(.WIDTH(4), .CNT_W(16)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (bus1.out_valid !== 1'b0 || bus1.sum !== 1'b0 || bus1.carry !== 1'b0) begin
         errors++;
         $display("FAIL reset_w1: ov/sum/carry=%b/%b/%b required 0/0/0",
                  bus1.out_valid, bus1.sum, bus1.carry);
      end
      vectors++;
      if (bus4.out_valid !== 1'b0 || bus4.sum !== 4'h0 || bus4.carry !== 4'h0) begin
         errors++;
         $display("FAIL reset_w4: ov/sum/carry=%b/%h/%h required 0/0/0",
                  bus4.out_valid, bus4.sum, bus4.carry);
      end
`ifdef HALF_ADDER_INTF_STATS_EN
      vectors++;
      if (bus1.op_count !== 4'd0 || bus1.carry_count !== 4'd0) begin
         errors++;
         $display("FAIL reset_counts: op=%0d carry=%0d required 0/0",
                  bus1.op_count, bus1.carry_count);
      end
`endif
      // in_valid present on the reset-release edge must be ignored
      @(negedge clk);
      bus1.in_valid = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1;
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (bus1.out_valid !== 1'b0 || bus1.carry !== 1'b0) begin
         errors++;
         $display("FAIL release_edge: ov/carry=%b/%b required 0/0",
                  bus1.out_valid, bus1.carry);
      end
`ifdef HALF_ADDER_INTF_STATS_EN
      vectors++;
      if (bus1.op_count !== 4'd0) begin
         errors++;
         $display("FAIL release_edge_count: op=%0d required 0", bus1.op_count);
      end
`endif
      @(negedge clk);
      bus1.in_valid = 1'b0;
   endtask

   task automatic test_exhaustive;
      logic [1:0] exp_tab [4] = '{2'b00, 2'b10, 2'b10, 2'b01};
      logic [1:0] exp;
      q1.delete();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus1.in_valid = 1'b1;
         bus1.a = 1'(i >> 1);
         bus1.b = 1'(i);
         q1.push_back(exp_tab[i]);
         @(posedge clk);
         #1;
         vectors++;
         if (bus1.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL exh_valid[%0d]: out_valid=%b required 1", i, bus1.out_valid);
            void'(q1.pop_front());
         end else begin
            exp = q1.pop_front();
            if ({bus1.sum, bus1.carry} !== exp) begin
               errors++;
               $display("FAIL exh_result[%0d]: sum,carry=%b%b required %b",
                        i, bus1.sum, bus1.carry, exp);
            end
         end
      end
      @(negedge clk);
      bus1.in_valid = 1'b0;
      @(posedge clk);
      #1;
      vectors++;
      if (bus1.out_valid !== 1'b0 || {bus1.sum, bus1.carry} !== 2'b01) begin
         errors++;
         $display("FAIL exh_hold: ov=%b sum,carry=%b%b required 0 and 01",
                  bus1.out_valid, bus1.sum, bus1.carry);
      end
   endtask

   task automatic test_comb;
      @(negedge clk);
      bus1.in_valid = 1'b1; bus1.a = 1'b0; bus1.b = 1'b1;
      @(negedge clk);
      bus1.in_valid = 1'b0; bus1.a = 1'b1; bus1.b = 1'b1;
      #1;
      vectors++;
      if (bus1.sum_comb !== 1'b0 || bus1.carry_comb !== 1'b1 ||
          bus1.sum !== 1'b1 || bus1.carry !== 1'b0) begin
         errors++;
         $display("FAIL comb: comb=%b%b reg=%b%b required comb 01 reg 10",
                  bus1.sum_comb, bus1.carry_comb, bus1.sum, bus1.carry);
      end
      @(negedge clk);
      bus1.a = 1'bx; bus1.b = 1'bz;
      @(posedge clk);
      #1;
      vectors++;
      if (bus1.out_valid !== 1'b0 || bus1.sum !== 1'b1 || bus1.carry !== 1'b0) begin
         errors++;
         $display("FAIL x_hold: ov=%b reg=%b%b required 0 and 10",
                  bus1.out_valid, bus1.sum, bus1.carry);
      end
      @(negedge clk);
      bus1.a = 1'b0; bus1.b = 1'b0;
   endtask

   task automatic test_multilane;
      logic [3:0] ra, rb;
      logic [7:0] exp;
      q4.delete();
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk);
         if (k == 10) begin
            bus4.in_valid = 1'b0;
         end else begin
            if (k == 0) begin
               ra = 4'b1100; rb = 4'b1010;
               q4.push_back(8'b0110_1000);
            end else begin
               ra = 4'($urandom_range(0, 15));
               rb = 4'($urandom_range(0, 15));
               q4.push_back({ra ^ rb, ra & rb});
            end
            bus4.in_valid = 1'b1; bus4.a = ra; bus4.b = rb;
            #1;
            vectors++;
            if ({bus4.sum_comb, bus4.carry_comb} !== q4[q4.size()-1]) begin
               errors++;
               $display("FAIL ml_comb[%0d]: %h%h required %h",
                        k, bus4.sum_comb, bus4.carry_comb, q4[q4.size()-1]);
            end
         end
         @(posedge clk);
         #1;
         vectors++;
         if (k == 10) begin
            if (bus4.out_valid !== 1'b0) begin
               errors++;
               $display("FAIL ml_idle: out_valid=%b required 0", bus4.out_valid);
            end
         end else if (bus4.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ml_valid[%0d]: out_valid=%b required 1", k, bus4.out_valid);
            void'(q4.pop_front());
         end else begin
            exp = q4.pop_front();
            if ({bus4.sum, bus4.carry} !== exp || (bus4.sum & bus4.carry) !== 4'h0) begin
               errors++;
               $display("FAIL ml_result[%0d]: sum=%b carry=%b required %b",
                        k, bus4.sum, bus4.carry, exp);
            end
         end
      end
   endtask

   task automatic test_async_reset;
      @(negedge clk);
      bus1.in_valid = 1'b1; bus1.a = 1'b1; bus1.b = 1'b0;
      @(posedge clk);
      #1;
      vectors++;
      if (bus1.out_valid !== 1'b1 || bus1.sum !== 1'b1) begin
         errors++;
         $display("FAIL ar_pre: ov/sum=%b/%b required 1/1", bus1.out_valid, bus1.sum);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (bus1.out_valid !== 1'b0 || bus1.sum !== 1'b0 || bus1.carry !== 1'b0) begin
         errors++;
         $display("FAIL ar_async: ov/sum/carry=%b/%b/%b required 0/0/0",
                  bus1.out_valid, bus1.sum, bus1.carry);
      end
      @(negedge clk);
      bus1.in_valid = 1'b0;
      @(posedge clk);
      #1;
      vectors++;
      if (bus1.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL ar_no_pulse: out_valid=%b required 0", bus1.out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (bus1.out_valid !== 1'b0 || bus4.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL ar_release: ov1/ov4=%b/%b required 0/0",
                  bus1.out_valid, bus4.out_valid);
      end
   endtask

`ifdef HALF_ADDER_INTF_STATS_EN
   task automatic test_stats;
      logic [1:0] pat [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
      @(negedge clk);
      bus1.stats_clr = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      bus1.stats_clr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus1.in_valid = 1'b1; bus1.a = pat[i][1]; bus1.b = pat[i][0];
      end
      @(negedge clk);
      bus1.in_valid = 1'b0;
      #1;
      vectors++;
      if (bus1.op_count !== 4'd5 || bus1.carry_count !== 4'd2) begin
         errors++;
         $display("FAIL stats_count: op=%0d carry=%0d required 5/2",
                  bus1.op_count, bus1.carry_count);
      end
      @(negedge clk);
      bus1.stats_clr = 1'b1;
      bus1.in_valid = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (bus1.op_count !== 4'd0 || bus1.carry_count !== 4'd0) begin
         errors++;
         $display("FAIL stats_clr: op=%0d carry=%0d required 0/0",
                  bus1.op_count, bus1.carry_count);
      end
      @(negedge clk);
      bus1.stats_clr = 1'b0;
      bus1.in_valid = 1'b0;
   endtask

   task automatic test_saturation;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         bus1.in_valid = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1;
         @(posedge clk);
         #1;
         if (i == 14) begin
            vectors++;
            if (bus1.op_count !== 4'd14) begin
               errors++;
               $display("FAIL sat_ramp: op=%0d required 14", bus1.op_count);
            end
         end
      end
      @(negedge clk);
      bus1.in_valid = 1'b0;
      #1;
      vectors++;
      if (bus1.op_count !== 4'd15 || bus1.carry_count !== 4'd15) begin
         errors++;
         $display("FAIL sat_top: op=%0d carry=%0d required 15/15",
                  bus1.op_count, bus1.carry_count);
      end
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (bus1.op_count !== 4'd15 || bus1.carry_count !== 4'd15) begin
         errors++;
         $display("FAIL sat_hold: op=%0d carry=%0d required 15/15",
                  bus1.op_count, bus1.carry_count);
      end
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus1.in_valid = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0;
      bus4.in_valid = 1'b0; bus4.a = 4'h0; bus4.b = 4'h0;
`ifdef HALF_ADDER_INTF_STATS_EN
      bus1.stats_clr = 1'b0;
      bus4.stats_clr = 1'b0;
`endif
      test_reset();
      test_exhaustive();
      test_comb();
      test_multilane();
      test_async_reset();
`ifdef HALF_ADDER_INTF_STATS_EN
      test_stats();
      test_saturation();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
`default_nettype wire
